mb_addr_cfg_ctrl: RTL and testbench
===================================

Name: mb_addr_cfg_ctrl

Overview:
Sequences network-address configuration after power-up. Waits for the MCU SPI address loader to finish, validates the received MAC and IP, and substitutes defaults or requests DHCP when they are unusable. Falls back to defaults on timeout. Offers the result to the Ethernet stack over a valid/ack handshake, then accepts later MCU reloads and DHCP-assigned IPs.

Parameters:
TIMEOUT_CYCLES, 122880000, clock cycles to wait for the MCU before using defaults (1 s at 122.88 MHz); minimum 2.
DEFAULT_MAC, 48'h00_1C_C0_A2_22_5D, fallback MAC; must be unicast and non-zero.
DEFAULT_IP, 32'h0, fallback IP; 0 means "use DHCP".

Ports:
clock  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
spi_mac  in  48  MAC from MCU SPI loader.
spi_ip  in  32  IP from MCU SPI loader.
spi_addr_read  in  1  loader done flag; sticky level, may already be high at reset release.
dhcp_ip  in  32  IP leased by DHCP client.
dhcp_ip_valid  in  1  one-cycle pulse, dhcp_ip valid.
cfg_ack  in  1  stack accepted the offered config.
mac  out  48  active MAC.
ip  out  32  active IP; 0 while DHCP is pending.
use_dhcp  out  1  stack must run DHCP.
cfg_valid  out  1  offer strobe; held until acked.
cfg_source  out  2  0 none, 1 MCU, 2 default, 3 DHCP.
mac_rejected  out  1  MCU MAC was invalid and replaced.
ip_rejected  out  1  MCU IP was invalid and replaced by DHCP.

Behaviour:
- Reset values:
  - outputs: mac=DEFAULT_MAC, ip=0, use_dhcp=0, cfg_valid=0, cfg_source=0, rejected flags=0.
  - internal: state=WAIT_MCU, timer=0, pending=0, edge-detect register=0.
- Edge detect: edge = spi_addr_read & ~prev. Because prev resets to 0, a level already high at reset release yields an edge on the first cycle.
- States:
  - WAIT_MCU: timer increments each cycle.
    - edge -> CHECK.
    - timer==TIMEOUT_CYCLES-1 with no edge -> OFFER with mac=DEFAULT_MAC, ip=DEFAULT_IP, use_dhcp=(DEFAULT_IP==0), source=2.
    - edge wins if both happen in the same cycle.
  - CHECK (1 cycle): registers the validated spi_mac/spi_ip, then goes to OFFER with source=1.
    - MAC invalid if all-0, all-1, or multicast bit mac[40]=1. Invalid -> mac=DEFAULT_MAC, mac_rejected=1; else mac_rejected=0.
    - IP==0 -> ip=0, use_dhcp=1, ip_rejected=0.
    - IP invalid if ip[31:24] is 0 or 127, or ip[31:28]>=4'hE (covers broadcast). Invalid -> ip=0, use_dhcp=1, ip_rejected=1.
    - Otherwise ip=spi_ip, use_dhcp=0, ip_rejected=0.
  - OFFER: cfg_valid=1; mac/ip/use_dhcp/source stable.
    - cfg_ack sampled high -> READY next cycle, cfg_valid=0.
    - An edge seen in OFFER sets pending. dhcp_ip_valid in OFFER is ignored.
  - READY:
    - pending or edge -> CHECK; pending is cleared.
    - Else dhcp_ip_valid with use_dhcp=1 -> ip=dhcp_ip, source=3, OFFER. use_dhcp stays 1 so the stack keeps renewing the lease.
    - dhcp_ip_valid with use_dhcp=0 is ignored.
    - An edge coinciding with dhcp_ip_valid wins; the DHCP pulse is dropped.
- Latency:
  - Edge sampled at cycle N -> CHECK at N+1 -> cfg_valid high at N+2.
  - ack at M -> cfg_valid low at M+1.
  - A DHCP pulse at N gives cfg_valid high at N+1.
- cfg_ack is ignored while cfg_valid=0.
- The timer runs only in WAIT_MCU and saturates at TIMEOUT_CYCLES-1. After a timeout offer, a later MCU edge still reconfigures, via READY or pending.
- Reset mid-operation: returns to reset values within the cycle reset is sampled; any offer in flight is abandoned.
- Timer width: $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package mb_addr_pkg contains:
  - state encoding (WAIT_MCU, CHECK, OFFER, READY);
  - cfg_source codes (SRC_NONE, SRC_MCU, SRC_DEFAULT, SRC_DHCP);
  - constants IP_BROADCAST, IP_LOOPBACK_OCTET=8'd127, MAC_MCAST_BIT=40.
- One sub-module, mb_addr_check: a combinational validator that takes mac/ip and returns mac_ok, ip_zero, ip_ok. It is unit-tested separately.

Test Plan:
- spi_addr_read rises, spi_mac=48'h00_11_22_33_44_55, spi_ip=C0A8_0164 -> cfg_valid high 2 cycles later; mac/ip are those values, source=1, use_dhcp=0. cfg_ack gives cfg_valid=0 next cycle.
- spi_mac=48'h01_00_5E_00_00_01, spi_ip=0 -> mac=DEFAULT_MAC, mac_rejected=1, ip=0, use_dhcp=1. Then dhcp_ip_valid with dhcp_ip=0A00_0005 in READY -> ip=0A00_0005, source=3, new offer.
- TIMEOUT_CYCLES=16, no MCU -> offer at cycle 16 with defaults, source=2. A later edge -> reconfigure with source=1.
- spi_ip=E000_0001, then 7F00_0001, then FFFF_FFFF -> each yields ip_rejected=1, use_dhcp=1, ip=0.
- Edge during OFFER, ack held off 10 cycles -> after ack, READY for 1 cycle, then CHECK and a new offer. Edge and dhcp_ip_valid in the same READY cycle -> MCU path taken, DHCP dropped.
- spi_addr_read high at reset release; reset reasserted while OFFER -> all outputs return to reset values. After reset, a single edge restarts CHECK.

Source files
------------

// File: rtl/mb_addr_cfg_ctrl_pkg.sv
// Shared definitions for the network-address configuration controller:
// controller state encoding, cfg_source codes and address-validation constants.
package mb_addr_pkg;

    typedef enum logic [1:0] {
        WAIT_MCU = 2'd0,
        CHECK    = 2'd1,
        OFFER    = 2'd2,
        READY    = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE    = 2'd0;
    localparam logic [1:0] SRC_MCU     = 2'd1;
    localparam logic [1:0] SRC_DEFAULT = 2'd2;
    localparam logic [1:0] SRC_DHCP    = 2'd3;

    localparam logic [31:0] IP_BROADCAST      = 32'hFFFF_FFFF;
    localparam logic [7:0]  IP_LOOPBACK_OCTET = 8'd127;
    localparam int          MAC_MCAST_BIT     = 40;

    // First (most significant) octet of a dotted-quad IPv4 address.
    function automatic logic [7:0] ip_first_octet(input logic [31:0] addr);
        return addr[31:24];
    endfunction

endpackage

// File: rtl/mb_addr_cfg_ctrl_check.sv
// Combinational validator for the MAC and IP handed over by the MCU loader.
// mac_ok : unicast, not all-zero, not all-one.
// ip_zero: address is 0 (caller treats this as "use DHCP", not as an error).
// ip_ok  : usable host address (not 0.x, not loopback, not class D/E/broadcast).
module mb_addr_check
    import mb_addr_pkg::*;
(
    input  logic [47:0] mac,
    input  logic [31:0] ip,
    output logic        mac_ok,
    output logic        ip_zero,
    output logic        ip_ok
);

    logic [7:0] octet_s;

    // Evaluate MAC and IP usability rules.
    always_comb begin
        octet_s = ip_first_octet(ip);
        mac_ok  = (mac != 48'h0) && (mac != {48{1'b1}}) && (mac[MAC_MCAST_BIT] == 1'b0);
        ip_zero = (ip == 32'h0);
        ip_ok   = (octet_s != 8'd0) && (octet_s != IP_LOOPBACK_OCTET) &&
                  (octet_s[7:4] < 4'hE) && (ip != IP_BROADCAST);
    end

endmodule

// File: rtl/mb_addr_cfg_ctrl.sv
// Power-up network-address sequencer: waits for the MCU loader, validates the
// received MAC/IP, falls back to defaults on timeout, offers the result to the
// Ethernet stack over valid/ack, then follows MCU reloads and DHCP leases.
module mb_addr_cfg_ctrl
    import mb_addr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 122880000,
    parameter logic [47:0] DEFAULT_MAC    = 48'h00_1C_C0_A2_22_5D,
    parameter logic [31:0] DEFAULT_IP     = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] spi_mac,
    input  logic [31:0] spi_ip,
    input  logic        spi_addr_read,
    input  logic [31:0] dhcp_ip,
    input  logic        dhcp_ip_valid,
    input  logic        cfg_ack,
    output logic [47:0] mac,
    output logic [31:0] ip,
    output logic        use_dhcp,
    output logic        cfg_valid,
    output logic [1:0]  cfg_source,
    output logic        mac_rejected,
    output logic        ip_rejected
);

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 32'd1);

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic            pending_r;
    logic            prev_r;
    logic            edge_s;
    logic            mac_ok_s;
    logic            ip_zero_s;
    logic            ip_ok_s;

    mb_addr_check u_check (
        .mac     (spi_mac),
        .ip      (spi_ip),
        .mac_ok  (mac_ok_s),
        .ip_zero (ip_zero_s),
        .ip_ok   (ip_ok_s)
    );

    // Rising edge of the sticky loader-done level; prev_r resets low so a level
    // already high at reset release counts as a fresh load.
    always_comb begin
        edge_s = spi_addr_read & ~prev_r;
    end

    // Configuration sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= WAIT_MCU;
            timer_r      <= '0;
            pending_r    <= 1'b0;
            prev_r       <= 1'b0;
            mac          <= DEFAULT_MAC;
            ip           <= 32'h0;
            use_dhcp     <= 1'b0;
            cfg_valid    <= 1'b0;
            cfg_source   <= SRC_NONE;
            mac_rejected <= 1'b0;
            ip_rejected  <= 1'b0;
        end else begin
            prev_r <= spi_addr_read;
            case (state_r)
                WAIT_MCU: begin
                    if (timer_r != TIMER_LAST) begin
                        timer_r <= timer_r + TW'(1'b1);
                    end
                    // A loader edge beats a simultaneous timeout.
                    if (edge_s) begin
                        state_r <= CHECK;
                    end else if (timer_r == TIMER_LAST) begin
                        mac          <= DEFAULT_MAC;
                        ip           <= DEFAULT_IP;
                        use_dhcp     <= (DEFAULT_IP == 32'h0);
                        cfg_source   <= SRC_DEFAULT;
                        mac_rejected <= 1'b0;
                        ip_rejected  <= 1'b0;
                        cfg_valid    <= 1'b1;
                        state_r      <= OFFER;
                    end
                end
                CHECK: begin
                    mac          <= mac_ok_s ? spi_mac : DEFAULT_MAC;
                    mac_rejected <= ~mac_ok_s;
                    if (ip_zero_s) begin
                        ip          <= 32'h0;
                        use_dhcp    <= 1'b1;
                        ip_rejected <= 1'b0;
                    end else if (!ip_ok_s) begin
                        ip          <= 32'h0;
                        use_dhcp    <= 1'b1;
                        ip_rejected <= 1'b1;
                    end else begin
                        ip          <= spi_ip;
                        use_dhcp    <= 1'b0;
                        ip_rejected <= 1'b0;
                    end
                    cfg_source <= SRC_MCU;
                    cfg_valid  <= 1'b1;
                    state_r    <= OFFER;
                end
                OFFER: begin
                    // Reloads arriving mid-offer are remembered, DHCP pulses are not.
                    if (edge_s) begin
                        pending_r <= 1'b1;
                    end
                    if (cfg_ack) begin
                        cfg_valid <= 1'b0;
                        state_r   <= READY;
                    end
                end
                READY: begin
                    if (pending_r || edge_s) begin
                        pending_r <= 1'b0;
                        state_r   <= CHECK;
                    end else if (dhcp_ip_valid && use_dhcp) begin
                        // use_dhcp stays set so the stack keeps renewing the lease.
                        ip         <= dhcp_ip;
                        cfg_source <= SRC_DHCP;
                        cfg_valid  <= 1'b1;
                        state_r    <= OFFER;
                    end
                end
                default: begin
                    cfg_valid <= 1'b0;
                    state_r   <= WAIT_MCU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_addr_cfg_ctrl.sv
// Self-checking bench for mb_addr_cfg_ctrl: directed scenarios plus randomized
// MCU reloads, compared against a transaction-level reference model.
module tb_mb_addr_cfg_ctrl;

    localparam logic [47:0] DEF_MAC = 48'h00_1C_C0_A2_22_5D;
    localparam logic [31:0] DEF_IP  = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic [47:0] spi_mac;
    logic [31:0] spi_ip;
    logic        spi_addr_read;
    logic [31:0] dhcp_ip;
    logic        dhcp_ip_valid;
    logic        cfg_ack;
    logic [47:0] mac;
    logic [31:0] ip;
    logic        use_dhcp;
    logic        cfg_valid;
    logic [1:0]  cfg_source;
    logic        mac_rejected;
    logic        ip_rejected;

    int compared   = 0;
    int mismatched = 0;

    // Reference model of the currently offered configuration.
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
    logic        exp_dhcp;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic        exp_mrej;
    logic        exp_irej;

    mb_addr_cfg_ctrl #(
        .TIMEOUT_CYCLES (16),
        .DEFAULT_MAC    (DEF_MAC),
        .DEFAULT_IP     (DEF_IP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .spi_mac       (spi_mac),
        .spi_ip        (spi_ip),
        .spi_addr_read (spi_addr_read),
        .dhcp_ip       (dhcp_ip),
        .dhcp_ip_valid (dhcp_ip_valid),
        .cfg_ack       (cfg_ack),
        .mac           (mac),
        .ip            (ip),
        .use_dhcp      (use_dhcp),
        .cfg_valid     (cfg_valid),
        .cfg_source    (cfg_source),
        .mac_rejected  (mac_rejected),
        .ip_rejected   (ip_rejected)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 48'(cfg_valid), 48'(exp_valid));
        chk({tag, "_mac"}, mac, exp_mac);
        chk({tag, "_ip"}, 48'(ip), 48'(exp_ip));
        chk({tag, "_dhcp"}, 48'(use_dhcp), 48'(exp_dhcp));
        chk({tag, "_src"}, 48'(cfg_source), 48'(exp_src));
        chk({tag, "_mrej"}, 48'(mac_rejected), 48'(exp_mrej));
        chk({tag, "_irej"}, 48'(ip_rejected), 48'(exp_irej));
    endtask

    function automatic void model_reset();
        exp_mac = DEF_MAC; exp_ip = 32'h0; exp_dhcp = 1'b0; exp_valid = 1'b0;
        exp_src = 2'd0; exp_mrej = 1'b0; exp_irej = 1'b0;
    endfunction

    // MCU-supplied addresses, judged by the address rules on whole octets.
    function automatic void model_mcu(input logic [47:0] m, input logic [31:0] a);
        int first_mac_octet;
        int first_ip_octet;
        first_mac_octet = int'(m >> 40);
        first_ip_octet  = int'(a >> 24);
        if (m == 48'h0 || m == 48'hFFFF_FFFF_FFFF || (first_mac_octet % 2) == 1) begin
            exp_mac = DEF_MAC; exp_mrej = 1'b1;
        end else begin
            exp_mac = m; exp_mrej = 1'b0;
        end
        if (a == 32'h0) begin
            exp_ip = 32'h0; exp_dhcp = 1'b1; exp_irej = 1'b0;
        end else if (first_ip_octet == 0 || first_ip_octet == 127 || first_ip_octet >= 224) begin
            exp_ip = 32'h0; exp_dhcp = 1'b1; exp_irej = 1'b1;
        end else begin
            exp_ip = a; exp_dhcp = 1'b0; exp_irej = 1'b0;
        end
        exp_src = 2'd1; exp_valid = 1'b1;
    endfunction

    // New MCU load from WAIT_MCU/READY: offer appears two cycles after the edge.
    task automatic do_reload(input string tag, input logic [47:0] m, input logic [31:0] a);
        if (spi_addr_read) begin
            spi_addr_read = 1'b0;
            step();
        end
        spi_mac = m; spi_ip = a; spi_addr_read = 1'b1;
        step();
        chk({tag, "_lat1"}, 48'(cfg_valid), 48'd0);
        step();
        model_mcu(m, a);
        check_all(tag);
    endtask

    task automatic do_ack(input string tag);
        cfg_ack = 1'b1;
        step();
        cfg_ack = 1'b0;
        exp_valid = 1'b0;
        chk({tag, "_ackdrop"}, 48'(cfg_valid), 48'(exp_valid));
    endtask

    initial begin
        logic [63:0] r64;
        logic [47:0] rm;
        logic [31:0] ri;

        reset = 1'b1; spi_mac = 48'h0; spi_ip = 32'h0; spi_addr_read = 1'b0;
        dhcp_ip = 32'h0; dhcp_ip_valid = 1'b0; cfg_ack = 1'b0;
        repeat (3) step();
        model_reset();
        check_all("reset");

        // Timeout with no MCU: defaults offered on the 16th cycle.
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("timeout_wait", 48'(cfg_valid), 48'd0);
        end
        step();
        exp_valid = 1'b1; exp_mac = DEF_MAC; exp_ip = DEF_IP; exp_dhcp = 1'b1;
        exp_src = 2'd2; exp_mrej = 1'b0; exp_irej = 1'b0;
        check_all("timeout");
        do_ack("timeout");

        // Later MCU load reconfigures from the MCU.
        do_reload("mcu_ok", 48'h00_11_22_33_44_55, 32'hC0A8_0164);
        do_ack("mcu_ok");

        // Multicast MAC and zero IP, then a DHCP lease.
        do_reload("mcast", 48'h01_00_5E_00_00_01, 32'h0);
        do_ack("mcast");
        dhcp_ip = 32'h0A00_0005; dhcp_ip_valid = 1'b1;
        step();
        dhcp_ip_valid = 1'b0;
        exp_ip = 32'h0A00_0005; exp_src = 2'd3; exp_valid = 1'b1;
        check_all("dhcp");
        do_ack("dhcp");

        // Ack while nothing is offered has no effect.
        cfg_ack = 1'b1;
        step();
        cfg_ack = 1'b0;
        chk("idle_ack", 48'(cfg_valid), 48'd0);

        // Edge and DHCP pulse in the same READY cycle: MCU wins.
        spi_addr_read = 1'b0;
        step();
        spi_mac = 48'h02_AA_BB_CC_DD_EE; spi_ip = 32'h0A01_0203; spi_addr_read = 1'b1;
        dhcp_ip = 32'h0B00_0001; dhcp_ip_valid = 1'b1;
        step();
        dhcp_ip_valid = 1'b0;
        chk("race_lat1", 48'(cfg_valid), 48'd0);
        step();
        model_mcu(48'h02_AA_BB_CC_DD_EE, 32'h0A01_0203);
        check_all("race");
        do_ack("race");

        // Unusable MCU IPs fall back to DHCP with ip_rejected.
        do_reload("ip_mcast", 48'h00_11_22_33_44_55, 32'hE000_0001);
        do_ack("ip_mcast");
        do_reload("ip_loop", 48'h00_11_22_33_44_55, 32'h7F00_0001);
        do_ack("ip_loop");
        do_reload("ip_bcast", 48'h00_11_22_33_44_55, 32'hFFFF_FFFF);
        do_ack("ip_bcast");

        // Reload arriving during an offer, ack held off.
        do_reload("pend_a", 48'h00_AA_00_00_00_01, 32'h0A00_0001);
        spi_addr_read = 1'b0;
        step();
        spi_mac = 48'h00_BB_00_00_00_02; spi_ip = 32'h0A00_0002; spi_addr_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pend_hold_valid", 48'(cfg_valid), 48'd1);
            chk("pend_hold_ip", 48'(ip), 48'(exp_ip));
        end
        do_ack("pend");
        step();
        chk("pend_check", 48'(cfg_valid), 48'd0);
        step();
        model_mcu(48'h00_BB_00_00_00_02, 32'h0A00_0002);
        check_all("pend_b");
        do_ack("pend_b");

        // Randomized reloads and DHCP pulses.
        for (int n = 0; n < 24; n++) begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rm = 48'h0;
                1: rm = 48'hFFFF_FFFF_FFFF;
                2: rm = r64[47:0] | 48'h01_00_00_00_00_00;
                default: rm = r64[47:0] & 48'hFE_FF_FF_FF_FF_FF;
            endcase
            case ($urandom_range(0, 4))
                0: ri = 32'h0;
                1: ri = {8'd127, r64[55:32]};
                2: ri = {8'd0, r64[55:32]};
                default: ri = $urandom;
            endcase
            do_reload("rnd", rm, ri);
            do_ack("rnd");
            dhcp_ip = $urandom; dhcp_ip_valid = 1'b1;
            step();
            dhcp_ip_valid = 1'b0;
            if (exp_dhcp) begin
                exp_ip = dhcp_ip; exp_src = 2'd3; exp_valid = 1'b1;
                check_all("rnd_dhcp");
                do_ack("rnd_dhcp");
            end else begin
                check_all("rnd_nodhcp");
            end
        end

        // Reset during an offer with the loader level held high.
        do_reload("pre_rst", 48'h00_12_34_56_78_9A, 32'hAC10_0001);
        reset = 1'b1;
        step();
        model_reset();
        check_all("mid_reset");
        step();
        reset = 1'b0;
        step();
        chk("post_rst_lat1", 48'(cfg_valid), 48'd0);
        step();
        model_mcu(48'h00_12_34_56_78_9A, 32'hAC10_0001);
        check_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
